// File: rtl/ureg_pkg.sv
// Shared definitions for the universal register: the 3-bit operation codes
// decoded by the next-state logic and used by anything that drives MODE.
package ureg_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_INC  = 3'b110;
  localparam logic [2:0] MODE_DEC  = 3'b111;

endpackage

// File: rtl/ureg_next.sv
// Combinational next-state datapath of the universal register: computes the
// candidate R, carry/shift-out and zero flag for the selected operation.
module ureg_next
  import ureg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] r,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] data,
  input  logic             sil,
  input  logic             sir,
  output logic [WIDTH-1:0] next_r,
  output logic             next_co,
  output logic             next_z
);

  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  // One bit wider than R so the carry/borrow falls out as the MSB.
  logic [WIDTH:0] sum;

  // NOTE: every output gets a default before the case so no path can leave
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    next_r  = r;
    next_co = 1'b0;
    sum     = '0;
    case (mode)
      MODE_LOAD: next_r = data;
      MODE_SHL: begin
        next_r  = {r[WIDTH-2:0], sil};
        next_co = r[WIDTH-1];
      end
      MODE_SHR: begin
        next_r  = {sir, r[WIDTH-1:1]};
        next_co = r[0];
      end
      MODE_ROL: begin
        next_r  = {r[WIDTH-2:0], r[WIDTH-1]};
        next_co = r[WIDTH-1];
      end
      MODE_ROR: begin
        next_r  = {r[0], r[WIDTH-1:1]};
        next_co = r[0];
      end
      MODE_INC: begin
        sum     = {1'b0, r} + ONE;
        next_r  = sum[WIDTH-1:0];
        next_co = sum[WIDTH];
      end
      MODE_DEC: begin
        sum     = {1'b0, r} - ONE;
        next_r  = sum[WIDTH-1:0];
        next_co = sum[WIDTH];
      end
      default: ;  // MODE_HOLD: the top level does not update state
    endcase
    next_z = (next_r == '0);
  end

endmodule

// File: rtl/univ_register.sv
// Universal register: WIDTH-bit storage with hold/load/shift/rotate/inc/dec,
// plus registered carry-out and zero flags. Synchronous active-high reset.
module univ_register
  import ureg_pkg::*;
#(
  parameter int               WIDTH  = 8,
  parameter logic [WIDTH-1:0] RSTVAL = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ENA,
  input  logic [2:0]       MODE,
  input  logic [WIDTH-1:0] DATA,
  input  logic             SIL,
  input  logic             SIR,
  output logic [WIDTH-1:0] R,
  output logic             CO,
  output logic             Z
);

  logic [WIDTH-1:0] next_r;
  logic             next_co;
  logic             next_z;

  ureg_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .r       (R),
    .mode    (MODE),
    .data    (DATA),
    .sil     (SIL),
    .sir     (SIR),
    .next_r  (next_r),
    .next_co (next_co),
    .next_z  (next_z)
  );

  // HOLD keeps CO as well as R, so it is folded into the enable rather than
  // decoded as "R <= R" in the datapath.
  logic update;
  assign update = ENA && (MODE != MODE_HOLD);

  // NOTE: all state uses non-blocking assignments so every flop samples the
  // pre-edge value of R; blocking here would create order-dependent races.
  // NOTE: only these WIDTH+2 flops exist and all are reset, so the zero
  // flag is consistent with RSTVAL straight out of reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      R  <= RSTVAL;
      CO <= 1'b0;
      Z  <= (RSTVAL == '0);
    end else if (update) begin
      R  <= next_r;
      CO <= next_co;
      Z  <= next_z;
    end
  end

endmodule
